mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 CLK  in  1  sole clock; all state updates on rising edge.
REQ-002 RESET  in  1  asynchronous, active-low reset.
REQ-003 MEM_V  in  1  valid instruction present from execute latch.
REQ-004 MEM_IR  in  32  instruction word; opcode/funct3 select the access.
REQ-005 MEM_NPC  in  64  next PC of the instruction, passed through.
REQ-006 MEM_ALU_RESULT  in  64  effective address for load/store, otherwise the result to forward.
REQ-007 MEM_ST_DATA  in  64  rs2 value for stores.
REQ-008 MEM_DRID  in  5  destination register id, passed through.
REQ-009 DM_REQ/DM_WE  out  1/1  data-memory request and write enable.
REQ-010 DM_ADDR  out  64  doubleword-aligned address (bits [2:0] zero).
REQ-011 DM_WDATA/DM_WSTRB  out  64/8  lane-shifted store data and byte strobes.
REQ-012 DM_ACK/DM_ERR  in  1/1  completion and access-fault, valid only while DM_REQ=1.
REQ-013 DM_RDATA  in  64  read doubleword, valid with DM_ACK.
REQ-014 MEM_STALL  out  1  holds execute and earlier stages.
REQ-015 WB_V, WB_IR(32), WB_NPC(64), WB_ALU_RESULT(64), WB_MEM_RESULT(64), WB_DRID(5)  out  writeback latch.
REQ-016 WB_EXC  out  1 and WB_CAUSE  out  64  exception flag and mcause value.

Function
REQ-017 Load = opcode 0000011 (funct3 LB/LH/LW/LD/LBU/LHU/LWU); store = 0100011 (SB/SH/SW/SD); other opcodes are non-memory.
REQ-018 Misaligned (addr mod size != 0) → no DM_REQ; cause 4 (load) or 6 (store).
REQ-019 FSM states IDLE, WAIT; reset state IDLE.
REQ-020 IDLE: MEM_V & aligned mem op → DM_REQ=1 combinationally the same cycle; DM_ACK that cycle → zero-wait completion, stay IDLE; else → WAIT.
REQ-021 WAIT: DM_REQ, DM_WE, DM_ADDR, DM_WDATA, DM_WSTRB held stable; DM_ACK → IDLE.
REQ-022 MEM_STALL = DM_REQ & !DM_ACK; never asserted for non-memory or misaligned instructions.
REQ-023 DM_ERR with DM_ACK → cause 5 (load) / 7 (store); WB_MEM_RESULT=0.
REQ-024 Load data: byte lane = addr[2:0]; sign-extend LB/LH/LW, zero-extend LBU/LHU/LWU, LD unmodified.
REQ-025 Store strobes: SB 1 bit, SH 2, SW 4, SD 0xFF, shifted by addr[2:0]; data replicated into the selected lanes.
REQ-026 WB latch loads every cycle MEM_STALL=0: WB_V=MEM_V, plus the passthrough fields; when MEM_STALL=1, WB_V=0 (bubble) and other WB fields hold.
REQ-027 MEM_V=0: no DM_REQ, WB_V=0 next cycle.
REQ-028 WB_EXC=1 only when WB_V=1; WB_CAUSE=0 when WB_EXC=0.
REQ-029 Input fields are held by upstream while MEM_STALL=1; the block does not re-latch them.

Reset
REQ-030 RESET low → immediately: state IDLE, WB_V=0, WB_EXC=0, all WB data fields 0.
REQ-031 DM_REQ=0 while RESET low; a pending WAIT is abandoned, late DM_ACK after release is ignored until a new request issues.

Structure
REQ-032 Opcodes, funct3 codes, cause values and FSM state encodings reside in shared package riscv_pkg.
REQ-033 Load extraction/extension is sub-module load_align (inputs rdata, addr[2:0], funct3; output 64-bit result), purely combinational.
REQ-034 Target size 150-300 lines RTL excluding package.

Verification
REQ-035 LD addr 0x1000, DM_ACK same cycle, RDATA 0x1122334455667788 → no stall, WB_MEM_RESULT=0x1122334455667788 next edge.
REQ-036 LB addr 0x1003, RDATA byte3=0x80, ACK after 3 cycles → MEM_STALL 3 cycles, 3 WB bubbles, then WB_MEM_RESULT=0xFFFFFFFFFFFFFF80.
REQ-037 SH addr 0x2006, ST_DATA 0xABCD → DM_ADDR 0x2000, WSTRB 0xC0, WDATA[63:48]=0xABCD.
REQ-038 LW addr 0x3002 → no DM_REQ, no stall, WB_EXC=1, WB_CAUSE=4.
REQ-039 SD with DM_ERR+ACK → WB_EXC=1, WB_CAUSE=7.
REQ-040 RESET low during WAIT → DM_REQ=0, WB_V=0 at once; after release, stray ACK produces no WB_V.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the memory stage.
// Holds the load/store opcodes, funct3 access codes, mcause values for memory
// exceptions, the memory-stage FSM state encodings, and small helpers that turn
// an access size (funct3[1:0]) into an alignment mask or a base byte strobe.
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 codes
    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    // mcause values
    localparam logic [63:0] CAUSE_LOAD_MISALIGNED  = 64'd4;
    localparam logic [63:0] CAUSE_LOAD_FAULT       = 64'd5;
    localparam logic [63:0] CAUSE_STORE_MISALIGNED = 64'd6;
    localparam logic [63:0] CAUSE_STORE_FAULT      = 64'd7;

    // Memory-stage FSM states
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Address bits that must be zero for an access of the given size.
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = 3'b000;
            2'd1:    size_mask = 3'b001;
            2'd2:    size_mask = 3'b011;
            default: size_mask = 3'b111;
        endcase
    endfunction

    // Byte strobe for lane 0; shifted by the address lane afterwards.
    function automatic logic [7:0] strb_base(input logic [1:0] sz);
        case (sz)
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   rdata  - 64-bit doubleword returned by data memory
//   addr   - byte lane of the access (effective address bits [2:0])
//   funct3 - load width/signedness code
//   result - loaded value, right-justified and sign/zero-extended to 64 bits
module load_align
    import riscv_pkg::*;
(
    input  logic [63:0] rdata,
    input  logic [2:0]  addr,
    input  logic [2:0]  funct3,
    output logic [63:0] result
);

    logic [63:0] shifted;

    always_comb begin
        // Move the addressed byte lane down to bit 0.
        shifted = rdata >> {addr, 3'b000};
        case (funct3)
            F3_LB:   result = {{56{shifted[7]}},  shifted[7:0]};
            F3_LH:   result = {{48{shifted[15]}}, shifted[15:0]};
            F3_LW:   result = {{32{shifted[31]}}, shifted[31:0]};
            F3_LBU:  result = {56'd0, shifted[7:0]};
            F3_LHU:  result = {48'd0, shifted[15:0]};
            F3_LWU:  result = {32'd0, shifted[31:0]};
            default: result = shifted;  // LD
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory stage: issues data-memory loads/stores, stalls upstream while an
// access is outstanding, detects misaligned and faulting accesses, and fills the
// writeback latch.
// Ports:
//   CLK, RESET                   - clock, asynchronous active-low reset
//   MEM_V/IR/NPC/ALU_RESULT/
//   ST_DATA/DRID                 - execute-latch inputs (held by upstream on stall)
//   DM_REQ/WE/ADDR/WDATA/WSTRB   - data-memory request channel
//   DM_ACK/ERR/RDATA             - data-memory response
//   MEM_STALL                    - holds execute and earlier stages
//   WB_*                         - writeback latch (valid, passthrough, load data)
//   WB_EXC/WB_CAUSE              - exception flag and mcause
module mem_stage
    import riscv_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_V,
    input  logic [31:0] MEM_IR,
    input  logic [63:0] MEM_NPC,
    input  logic [63:0] MEM_ALU_RESULT,
    input  logic [63:0] MEM_ST_DATA,
    input  logic [4:0]  MEM_DRID,
    output logic        DM_REQ,
    output logic        DM_WE,
    output logic [63:0] DM_ADDR,
    output logic [63:0] DM_WDATA,
    output logic [7:0]  DM_WSTRB,
    input  logic        DM_ACK,
    input  logic        DM_ERR,
    input  logic [63:0] DM_RDATA,
    output logic        MEM_STALL,
    output logic        WB_V,
    output logic [31:0] WB_IR,
    output logic [63:0] WB_NPC,
    output logic [63:0] WB_ALU_RESULT,
    output logic [63:0] WB_MEM_RESULT,
    output logic [4:0]  WB_DRID,
    output logic        WB_EXC,
    output logic [63:0] WB_CAUSE
);

    logic [0:0]  state_q, state_d;
    logic        wb_v_q, wb_v_d;
    logic [31:0] wb_ir_q, wb_ir_d;
    logic [63:0] wb_npc_q, wb_npc_d;
    logic [63:0] wb_alu_q, wb_alu_d;
    logic [63:0] wb_mem_q, wb_mem_d;
    logic [4:0]  wb_drid_q, wb_drid_d;
    logic        wb_exc_q, wb_exc_d;
    logic [63:0] wb_cause_q, wb_cause_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [2:0]  lane;
    logic        is_load, is_store, misaligned, access, done;
    logic [63:0] load_result;

    // Decode and request generation
    always_comb begin
        opcode     = MEM_IR[6:0];
        funct3     = MEM_IR[14:12];
        lane       = MEM_ALU_RESULT[2:0];
        // funct3 values without a defined access are treated as non-memory.
        is_load    = (opcode == OPC_LOAD) && (funct3 != 3'b111);
        is_store   = (opcode == OPC_STORE) && !funct3[2];
        misaligned = |(lane & size_mask(funct3[1:0]));
        access     = MEM_V && (is_load || is_store) && !misaligned;

        // Request is gated by reset so a pending WAIT drops immediately.
        DM_REQ    = RESET && ((state_q == ST_WAIT) || access);
        DM_WE     = DM_REQ && is_store;
        DM_ADDR   = {MEM_ALU_RESULT[63:3], 3'b000};
        DM_WSTRB  = DM_WE ? (strb_base(funct3[1:0]) << lane) : 8'h00;
        // Replicating the store data over all lanes places it in whichever
        // lanes the strobe selects, since aligned accesses never straddle.
        case (funct3[1:0])
            2'd0:    DM_WDATA = {8{MEM_ST_DATA[7:0]}};
            2'd1:    DM_WDATA = {4{MEM_ST_DATA[15:0]}};
            2'd2:    DM_WDATA = {2{MEM_ST_DATA[31:0]}};
            default: DM_WDATA = MEM_ST_DATA;
        endcase

        MEM_STALL = DM_REQ && !DM_ACK;
        done      = DM_REQ && DM_ACK;
    end

    load_align u_load_align (
        .rdata  (DM_RDATA),
        .addr   (lane),
        .funct3 (funct3),
        .result (load_result)
    );

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (DM_REQ && !DM_ACK) state_d = ST_WAIT;
            default: if (DM_ACK)            state_d = ST_IDLE;
        endcase
    end

    // Writeback latch next state
    always_comb begin
        wb_v_d     = wb_v_q;
        wb_ir_d    = wb_ir_q;
        wb_npc_d   = wb_npc_q;
        wb_alu_d   = wb_alu_q;
        wb_mem_d   = wb_mem_q;
        wb_drid_d  = wb_drid_q;
        wb_exc_d   = wb_exc_q;
        wb_cause_d = wb_cause_q;

        if (MEM_STALL) begin
            // Bubble: data fields hold, but the exception flag must not
            // outlive a valid entry.
            wb_v_d     = 1'b0;
            wb_exc_d   = 1'b0;
            wb_cause_d = 64'd0;
        end else begin
            wb_v_d     = MEM_V;
            wb_ir_d    = MEM_IR;
            wb_npc_d   = MEM_NPC;
            wb_alu_d   = MEM_ALU_RESULT;
            wb_drid_d  = MEM_DRID;
            wb_exc_d   = 1'b0;
            wb_cause_d = 64'd0;
            wb_mem_d   = 64'd0;
            if (MEM_V && (is_load || is_store) && misaligned) begin
                wb_exc_d   = 1'b1;
                wb_cause_d = is_load ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
            end else if (done && DM_ERR) begin
                wb_exc_d   = 1'b1;
                wb_cause_d = is_load ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
            end else if (done && is_load) begin
                wb_mem_d = load_result;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            wb_v_q     <= 1'b0;
            wb_ir_q    <= 32'd0;
            wb_npc_q   <= 64'd0;
            wb_alu_q   <= 64'd0;
            wb_mem_q   <= 64'd0;
            wb_drid_q  <= 5'd0;
            wb_exc_q   <= 1'b0;
            wb_cause_q <= 64'd0;
        end else begin
            state_q    <= state_d;
            wb_v_q     <= wb_v_d;
            wb_ir_q    <= wb_ir_d;
            wb_npc_q   <= wb_npc_d;
            wb_alu_q   <= wb_alu_d;
            wb_mem_q   <= wb_mem_d;
            wb_drid_q  <= wb_drid_d;
            wb_exc_q   <= wb_exc_d;
            wb_cause_q <= wb_cause_d;
        end
    end

    always_comb begin
        WB_V          = wb_v_q;
        WB_IR         = wb_ir_q;
        WB_NPC        = wb_npc_q;
        WB_ALU_RESULT = wb_alu_q;
        WB_MEM_RESULT = wb_mem_q;
        WB_DRID       = wb_drid_q;
        WB_EXC        = wb_exc_q;
        WB_CAUSE      = wb_cause_q;
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized
// loads/stores/non-memory ops checked against a byte-level reference model.
module tb_mem_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        MEM_V = 1'b0;
    logic [31:0] MEM_IR = '0;
    logic [63:0] MEM_NPC = '0;
    logic [63:0] MEM_ALU_RESULT = '0;
    logic [63:0] MEM_ST_DATA = '0;
    logic [4:0]  MEM_DRID = '0;
    logic        DM_REQ, DM_WE;
    logic [63:0] DM_ADDR, DM_WDATA;
    logic [7:0]  DM_WSTRB;
    logic        DM_ACK = 1'b0;
    logic        DM_ERR = 1'b0;
    logic [63:0] DM_RDATA = '0;
    logic        MEM_STALL, WB_V, WB_EXC;
    logic [31:0] WB_IR;
    logic [63:0] WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CAUSE;
    logic [4:0]  WB_DRID;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .MEM_V          (MEM_V),
        .MEM_IR         (MEM_IR),
        .MEM_NPC        (MEM_NPC),
        .MEM_ALU_RESULT (MEM_ALU_RESULT),
        .MEM_ST_DATA    (MEM_ST_DATA),
        .MEM_DRID       (MEM_DRID),
        .DM_REQ         (DM_REQ),
        .DM_WE          (DM_WE),
        .DM_ADDR        (DM_ADDR),
        .DM_WDATA       (DM_WDATA),
        .DM_WSTRB       (DM_WSTRB),
        .DM_ACK         (DM_ACK),
        .DM_ERR         (DM_ERR),
        .DM_RDATA       (DM_RDATA),
        .MEM_STALL      (MEM_STALL),
        .WB_V           (WB_V),
        .WB_IR          (WB_IR),
        .WB_NPC         (WB_NPC),
        .WB_ALU_RESULT  (WB_ALU_RESULT),
        .WB_MEM_RESULT  (WB_MEM_RESULT),
        .WB_DRID        (WB_DRID),
        .WB_EXC         (WB_EXC),
        .WB_CAUSE       (WB_CAUSE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] make_ir(input logic [6:0] opc, input logic [2:0] f3);
        logic [31:0] r;
        r = $urandom;
        r[14:12] = f3;
        r[6:0] = opc;
        return r;
    endfunction

    // Runs one instruction through the stage. The reference model works on
    // bytes: access size in bytes, alignment by modulo, lanes filled one by one.
    task automatic run_op(input logic v, input logic [31:0] ir, input logic [63:0] addr,
                          input logic [63:0] st, input logic [63:0] rd,
                          input int delay, input logic err);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        ld, sto, mis, acc, exp_exc;
        int          nb, ln;
        logic [7:0]  e_strb;
        logic [63:0] e_wdata, e_mask, e_lres, e_cause, e_mem, npc;
        logic [4:0]  drid;

        opc = ir[6:0];
        f3  = ir[14:12];
        ld  = (opc == 7'b0000011) && (f3 <= 3'd6);
        sto = (opc == 7'b0100011) && (f3 <= 3'd3);
        nb  = 1 << f3[1:0];
        ln  = int'(addr % 8);
        mis = (addr % nb) != 0;
        acc = v && (ld || sto) && !mis;

        e_strb = '0; e_wdata = '0; e_mask = '0; e_lres = '0;
        if (!mis) begin
            for (int i = 0; i < nb; i++) begin
                e_strb[ln + i] = 1'b1;
                e_mask[8 * (ln + i) +: 8] = 8'hFF;
                e_wdata[8 * (ln + i) +: 8] = st[8 * i +: 8];
                e_lres[8 * i +: 8] = rd[8 * (ln + i) +: 8];
            end
            if (!f3[2] && nb < 8 && e_lres[8 * nb - 1])
                for (int i = nb; i < 8; i++) e_lres[8 * i +: 8] = 8'hFF;
        end

        exp_exc = v && (ld || sto) && (mis || err && acc);
        e_cause = !exp_exc ? 64'd0 :
                  mis ? (ld ? 64'd4 : 64'd6) : (ld ? 64'd5 : 64'd7);
        e_mem   = (acc && ld && !err) ? e_lres : 64'd0;

        npc  = {$urandom, $urandom};
        drid = 5'($urandom);
        MEM_V = v; MEM_IR = ir; MEM_ALU_RESULT = addr; MEM_ST_DATA = st;
        MEM_NPC = npc; MEM_DRID = drid; DM_RDATA = rd;
        DM_ACK = acc && (delay == 0);
        DM_ERR = DM_ACK && err;
        #2;
        check("dm_req", DM_REQ, acc);
        check("stall", MEM_STALL, acc && (delay > 0));
        if (acc) begin
            check("dm_addr", DM_ADDR, {addr[63:3], 3'b000});
            check("dm_we", DM_WE, sto);
            check("dm_wstrb", DM_WSTRB, sto ? e_strb : 8'h00);
            if (sto) check("dm_wdata", DM_WDATA & e_mask, e_wdata);
            for (int i = 0; i < delay; i++) begin
                cycle();
                check("bubble_v", WB_V, 1'b0);
                check("bubble_exc", WB_EXC, 1'b0);
                if (i == delay - 1) begin
                    DM_ACK = 1'b1;
                    DM_ERR = err;
                end
                #2;
                check("wait_req", DM_REQ, 1'b1);
                check("wait_addr", DM_ADDR, {addr[63:3], 3'b000});
                check("wait_strb", DM_WSTRB, sto ? e_strb : 8'h00);
                check("wait_stall", MEM_STALL, i != delay - 1);
            end
        end
        cycle();
        DM_ACK = 1'b0;
        DM_ERR = 1'b0;
        check("wb_v", WB_V, v);
        check("wb_exc", WB_EXC, exp_exc);
        check("wb_cause", WB_CAUSE, e_cause);
        if (v) begin
            check("wb_mem", WB_MEM_RESULT, e_mem);
            check("wb_npc", WB_NPC, npc);
            check("wb_drid", WB_DRID, drid);
            check("wb_ir", WB_IR, ir);
            check("wb_alu", WB_ALU_RESULT, addr);
        end
    endtask

    initial begin
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] a;
        int          kind;

        // Reset state
        #3 RESET = 1'b0;
        MEM_V = 1'b1;
        MEM_IR = make_ir(7'b0000011, 3'b011);
        MEM_ALU_RESULT = 64'h1000;
        #1;
        check("rst_req", DM_REQ, 1'b0);
        check("rst_stall", MEM_STALL, 1'b0);
        check("rst_wb_v", WB_V, 1'b0);
        check("rst_wb_exc", WB_EXC, 1'b0);
        check("rst_wb_cause", WB_CAUSE, 64'd0);
        check("rst_wb_mem", WB_MEM_RESULT, 64'd0);
        check("rst_wb_npc", WB_NPC, 64'd0);
        check("rst_wb_ir", WB_IR, 64'd0);
        check("rst_wb_alu", WB_ALU_RESULT, 64'd0);
        check("rst_wb_drid", WB_DRID, 64'd0);
        MEM_V = 1'b0;
        cycle();
        RESET = 1'b1;
        cycle();
        check("idle_wb_v", WB_V, 1'b0);

        // LD zero-wait
        run_op(1'b1, make_ir(7'b0000011, 3'b011), 64'h1000, 64'd0,
               64'h1122334455667788, 0, 1'b0);
        check("ld_zero_wait", WB_MEM_RESULT, 64'h1122334455667788);

        // LB with three wait cycles, negative byte
        run_op(1'b1, make_ir(7'b0000011, 3'b000), 64'h1003, 64'd0,
               64'h0000_0000_8000_0000, 3, 1'b0);
        check("lb_sext", WB_MEM_RESULT, 64'hFFFF_FFFF_FFFF_FF80);

        // SH lane 6
        MEM_V = 1'b1;
        MEM_IR = make_ir(7'b0100011, 3'b001);
        MEM_ALU_RESULT = 64'h2006;
        MEM_ST_DATA = 64'hABCD;
        DM_ACK = 1'b1;
        #2;
        check("sh_addr", DM_ADDR, 64'h2000);
        check("sh_strb", DM_WSTRB, 8'hC0);
        check("sh_wdata", {48'd0, DM_WDATA[63:48]}, 64'hABCD);
        check("sh_we", DM_WE, 1'b1);
        cycle();
        DM_ACK = 1'b0;
        check("sh_wb_v", WB_V, 1'b1);

        // Misaligned LW
        run_op(1'b1, make_ir(7'b0000011, 3'b010), 64'h3002, 64'd0, 64'd0, 0, 1'b0);
        check("lw_mis_exc", WB_EXC, 1'b1);
        check("lw_mis_cause", WB_CAUSE, 64'd4);

        // SD access fault
        run_op(1'b1, make_ir(7'b0100011, 3'b011), 64'h4008, 64'h55, 64'd0, 1, 1'b1);
        check("sd_fault_exc", WB_EXC, 1'b1);
        check("sd_fault_cause", WB_CAUSE, 64'd7);

        // Reset during WAIT, then a stray ACK
        MEM_V = 1'b1;
        MEM_IR = make_ir(7'b0000011, 3'b011);
        MEM_ALU_RESULT = 64'h5000;
        DM_ACK = 1'b0;
        #2;
        check("rw_req", DM_REQ, 1'b1);
        cycle();
        cycle();
        #2 RESET = 1'b0;
        #1;
        check("rw_req_drop", DM_REQ, 1'b0);
        check("rw_wb_v", WB_V, 1'b0);
        check("rw_stall", MEM_STALL, 1'b0);
        MEM_V = 1'b0;
        DM_ACK = 1'b1;
        cycle();
        RESET = 1'b1;
        cycle();
        check("stray_ack_v", WB_V, 1'b0);
        check("stray_ack_req", DM_REQ, 1'b0);
        cycle();
        check("stray_ack_v2", WB_V, 1'b0);
        DM_ACK = 1'b0;

        // Randomized mix
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3) begin
                opc = 7'b0000011; f3 = 3'($urandom_range(0, 6));
            end else if (kind <= 6) begin
                opc = 7'b0100011; f3 = 3'($urandom_range(0, 3));
            end else if (kind == 7) begin
                opc = 7'b0110011; f3 = 3'($urandom);
            end else begin
                opc = 7'b1100011; f3 = 3'($urandom);
            end
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a[2:0] = a[2:0] & ~((3'd1 << f3[1:0]) - 3'd1);
            run_op($urandom_range(0, 7) != 0, make_ir(opc, f3), a, {$urandom, $urandom},
                   {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 7) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
